ccd_frame_capture: RTL and testbench

- Upstream stage of image_processing_module. Converts the raw sensor stream into the qualified, coordinate-tagged pixel stream that module consumes.
- Input side: iDATA qualified by frame-valid and line-valid.
- Output side: oDATA, oDVAL, oX_Cont and oY_Cont, which drive iDATA/iDVAL/iX_Cont/iY_Cont directly.
- Host iSTART/iEND gate capture on whole-frame boundaries only. A frame counter and a frame-done pulse are exported.

---
 rtl/ccd_capture_pkg.sv | 17 +
 rtl/ccd_frame_capture.sv | 211 +++++++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_capture_pkg.sv
// Shared definitions for the CCD frame capture front end: state encoding and
// default stream widths.
package ccd_capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    FRAME    = 2'd2
  } state_t;

  localparam int CCD_DATA_W   = 12;
  localparam int CCD_X_W      = 11;
  localparam int CCD_Y_W      = 11;
  localparam int CCD_H_ACTIVE = 1280;
  localparam int CCD_FC_W     = 32;

endpackage

// File: rtl/ccd_frame_capture.sv
// Converts the raw frame/line-valid sensor stream into a coordinate-tagged
// pixel stream, capturing only whole frames between host start/stop requests.
module ccd_frame_capture
  import ccd_capture_pkg::*;
#(
  parameter int DATA_W   = CCD_DATA_W,
  parameter int X_W      = CCD_X_W,
  parameter int Y_W      = CCD_Y_W,
  parameter int H_ACTIVE = CCD_H_ACTIVE,
  parameter int FC_W     = CCD_FC_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [X_W-1:0]    oX_Cont,
  output logic [Y_W-1:0]    oY_Cont,
  output logic [FC_W-1:0]   oFrame_Cont,
  output logic              oFrame_Done,
  output logic              oBusy
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_MAX  = {Y_W{1'b1}};

  // Row advance that saturates at the top of the counter range.
  function automatic logic [Y_W-1:0] y_step(input logic [Y_W-1:0] y);
    if (y == Y_MAX) begin
      return y;
    end else begin
      return y + Y_W'(1);
    end
  endfunction

  logic [DATA_W-1:0] data_q_r;
  logic              fval_q_r;
  logic              lval_q_r;
  logic              fval_qq_r;
  logic              lval_qq_r;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              seen_low_r;
  logic              seen_low_nxt_s;
  logic              stop_req_r;
  logic              stop_req_nxt_s;
  logic [X_W-1:0]    x_cnt_r;
  logic [X_W-1:0]    x_nxt_s;
  logic [Y_W-1:0]    y_cnt_r;
  logic [Y_W-1:0]    y_nxt_s;
  logic              frame_end_s;

  logic [DATA_W-1:0] data_o_r;
  logic              dval_o_r;
  logic [X_W-1:0]    x_o_r;
  logic [Y_W-1:0]    y_o_r;
  logic [FC_W-1:0]   frame_cnt_r;
  logic              frame_done_r;
  logic              busy_r;

  logic sof_s;
  logic eof_s;
  logic pix_s;
  logic pix_out_s;

  assign sof_s     = fval_q_r & ~fval_qq_r;
  assign eof_s     = ~fval_q_r & fval_qq_r;
  assign pix_s     = fval_q_r & lval_q_r;
  assign pix_out_s = (state_r == FRAME) & pix_s;

  // Input stage: sensor sample plus one extra tap of the valids for edge detection.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      data_q_r  <= {DATA_W{1'b0}};
      fval_q_r  <= 1'b0;
      lval_q_r  <= 1'b0;
      fval_qq_r <= 1'b0;
      lval_qq_r <= 1'b0;
    end else begin
      data_q_r  <= iDATA;
      fval_q_r  <= iFVAL;
      lval_q_r  <= iLVAL;
      fval_qq_r <= fval_q_r;
      lval_qq_r <= lval_q_r;
    end
  end

  // Control state, arming flags and pixel coordinate counters.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_r    <= IDLE;
      seen_low_r <= 1'b0;
      stop_req_r <= 1'b0;
      x_cnt_r    <= {X_W{1'b0}};
      y_cnt_r    <= {Y_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      seen_low_r <= seen_low_nxt_s;
      stop_req_r <= stop_req_nxt_s;
      x_cnt_r    <= x_nxt_s;
      y_cnt_r    <= y_nxt_s;
    end
  end

  // Next-state logic; seen_low guarantees a frame is only entered from a true low->high FVAL edge.
  always_comb begin
    state_nxt_s    = state_r;
    seen_low_nxt_s = seen_low_r;
    stop_req_nxt_s = stop_req_r;
    x_nxt_s        = x_cnt_r;
    y_nxt_s        = y_cnt_r;
    frame_end_s    = 1'b0;
    case (state_r)
      IDLE: begin
        stop_req_nxt_s = 1'b0;
        if (iSTART & ~iEND) begin
          state_nxt_s    = WAIT_SOF;
          seen_low_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_SOF: begin
        stop_req_nxt_s = 1'b0;
        if (iEND) begin
          state_nxt_s = IDLE;
        end else if (sof_s & seen_low_r) begin
          state_nxt_s = FRAME;
          x_nxt_s     = {X_W{1'b0}};
          y_nxt_s     = {Y_W{1'b0}};
        end else if (!fval_q_r) begin
          seen_low_nxt_s = 1'b1;
        end else begin
          seen_low_nxt_s = seen_low_r;
        end
      end
      FRAME: begin
        if (eof_s) begin
          frame_end_s    = 1'b1;
          stop_req_nxt_s = 1'b0;
          if (stop_req_r | iEND) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s    = WAIT_SOF;
            seen_low_nxt_s = 1'b1;
          end
        end else if (iEND) begin
          stop_req_nxt_s = 1'b1;
        end else begin
          stop_req_nxt_s = stop_req_r;
        end
        // A line that ends before H_ACTIVE pixels still advances the row.
        if (pix_s) begin
          if (x_cnt_r == X_LAST) begin
            x_nxt_s = {X_W{1'b0}};
            y_nxt_s = y_step(y_cnt_r);
          end else begin
            x_nxt_s = x_cnt_r + X_W'(1);
          end
        end else if (~lval_q_r & lval_qq_r & (x_cnt_r != {X_W{1'b0}})) begin
          x_nxt_s = {X_W{1'b0}};
          y_nxt_s = y_step(y_cnt_r);
        end else begin
          x_nxt_s = x_cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output stage: pixel, its coordinates, frame accounting and busy flag.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      data_o_r     <= {DATA_W{1'b0}};
      dval_o_r     <= 1'b0;
      x_o_r        <= {X_W{1'b0}};
      y_o_r        <= {Y_W{1'b0}};
      frame_cnt_r  <= {FC_W{1'b0}};
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_o_r     <= data_q_r;
      dval_o_r     <= pix_out_s;
      frame_done_r <= frame_end_s;
      busy_r       <= (state_r != IDLE);
      if (pix_out_s) begin
        x_o_r <= x_cnt_r;
        y_o_r <= y_cnt_r;
      end
      if (frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + FC_W'(1);
      end
    end
  end

  assign oDATA       = data_o_r;
  assign oDVAL       = dval_o_r;
  assign oX_Cont     = x_o_r;
  assign oY_Cont     = y_o_r;
  assign oFrame_Cont = frame_cnt_r;
  assign oFrame_Done = frame_done_r;
  assign oBusy       = busy_r;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Scoreboard bench for ccd_frame_capture: directed frames push expected pixels,
// an independent monitor pops and compares on every oDVAL.
module tb_ccd_frame_capture;

  localparam int DW = 12;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int HA = 8;
  localparam int FW = 32;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic          iFVAL = 1'b0;
  logic          iLVAL = 1'b0;
  logic          iSTART = 1'b0;
  logic          iEND = 1'b0;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic [XW-1:0] oX_Cont;
  logic [YW-1:0] oY_Cont;
  logic [FW-1:0] oFrame_Cont;
  logic          oFrame_Done;
  logic          oBusy;

  ccd_frame_capture #(
    .DATA_W(DW), .X_W(XW), .Y_W(YW), .H_ACTIVE(HA), .FC_W(FW)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oFrame_Done(oFrame_Done), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [DW-1:0] d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int pix_seen = 0;
  int done_seen = 0;
  int cyc = 0;

  always @(posedge iCLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every presented pixel must match the head of the scoreboard.
  always @(negedge iCLK) begin
    if (oFrame_Done === 1'b1) done_seen++;
    if (oDVAL === 1'b1) begin
      pix_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dval: actual oDVAL=1 (x=%0d y=%0d) required no pixel", oX_Cont, oY_Cont);
      end else begin
        mon_e = sb.pop_front();
        chk("pix_data", oDATA, mon_e.d);
        chk("pix_x", oX_Cont, mon_e.x);
        chk("pix_y", oY_Cont, mon_e.y);
        chk("pix_latency", cyc - mon_e.cyc, 2);
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic fv, input logic lv, input logic [DW-1:0] d);
    iFVAL = fv;
    iLVAL = lv;
    iDATA = d;
    tick();
  endtask

  task automatic check_reset_outputs();
    @(negedge iCLK);
    chk("rst_dval", oDVAL, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_x", oX_Cont, 0);
    chk("rst_y", oY_Cont, 0);
    chk("rst_cont", oFrame_Cont, 0);
    chk("rst_done", oFrame_Done, 0);
    chk("rst_busy", oBusy, 0);
  endtask

  task automatic do_reset();
    iRST = 1'b0;
    drive(1'b0, 1'b0, 12'h5A5);
    check_reset_outputs();
    tick();
    iRST = 1'b1;
    tick();
    pix_seen  = 0;
    done_seen = 0;
  endtask

  task automatic arm();
    iSTART = 1'b1;
    drive(1'b0, 1'b0, 12'h000);
    iSTART = 1'b0;
  endtask

  // One frame: FVAL low gap, two blanking cycles, four lines, trailing high cycle.
  task automatic run_frame(input int l0len, input bit cap, input int start_line,
                           input int end_line, input int base);
    int k;
    int len;
    k = 0;
    for (int g = 0; g < 4; g++) drive(1'b0, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 12'h000);
    for (int l = 0; l < 4; l++) begin
      len = (l == 0) ? l0len : HA;
      iSTART = (l == start_line);
      iEND   = (l == end_line);
      for (int p = 0; p < len; p++) begin
        if (cap) sb.push_back('{d: DW'(base + k), x: XW'(p), y: YW'(l), cyc: cyc});
        drive(1'b1, 1'b1, DW'(base + k));
        k++;
        iSTART = 1'b0;
        iEND   = 1'b0;
      end
      for (int b = 0; b < 3; b++) drive(1'b1, 1'b0, 12'h000);
    end
    drive(1'b1, 1'b0, 12'h000);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 12'h000);
  endtask

  task automatic end_test(input string tag, input int exp_pix, input int exp_cont, input logic exp_busy);
    chk({tag, "_pixels"}, pix_seen, exp_pix);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_frame_cont"}, oFrame_Cont, exp_cont);
    chk({tag, "_done_pulses"}, done_seen, exp_cont);
    chk({tag, "_busy"}, oBusy, exp_busy);
    sb.delete();
  endtask

  initial begin
    // T1: armed capture of a full 4x8 frame
    do_reset();
    arm();
    drive(1'b0, 1'b0, 12'h000);
    chk("t1_busy_armed", oBusy, 1);
    run_frame(HA, 1'b1, -1, -1, 0);
    drain();
    end_test("t1", 32, 1, 1'b1);

    // T2: no start, nothing captured
    do_reset();
    run_frame(HA, 1'b0, -1, -1, 100);
    drain();
    end_test("t2", 0, 0, 1'b0);

    // T3: start mid-frame, only the following frame is captured
    do_reset();
    run_frame(HA, 1'b0, 2, -1, 200);
    run_frame(HA, 1'b1, -1, -1, 300);
    drain();
    end_test("t3", 32, 1, 1'b1);

    // T4: stop request during frame 2 of a continuous stream
    do_reset();
    arm();
    run_frame(HA, 1'b1, -1, -1, 400);
    run_frame(HA, 1'b1, -1, 1, 500);
    drain();
    chk("t4_busy_after_stop", oBusy, 0);
    run_frame(HA, 1'b0, -1, -1, 600);
    drain();
    end_test("t4", 64, 2, 1'b0);

    // T5: short first line
    do_reset();
    arm();
    run_frame(5, 1'b1, -1, -1, 700);
    drain();
    chk("t5_last_y", oY_Cont, 3);
    chk("t5_last_x", oX_Cont, HA - 1);
    end_test("t5", 29, 1, 1'b1);

    // T6: reset in the middle of a captured frame with FVAL held high
    do_reset();
    arm();
    for (int g = 0; g < 4; g++) drive(1'b0, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 12'h000);
    for (int p = 0; p < HA; p++) begin
      sb.push_back('{d: DW'(800 + p), x: XW'(p), y: YW'(0), cyc: cyc});
      drive(1'b1, 1'b1, DW'(800 + p));
    end
    for (int b = 0; b < 4; b++) drive(1'b1, 1'b0, 12'h000);
    chk("t6_pre_rst_pixels", pix_seen, HA);
    chk("t6_pre_rst_busy", oBusy, 1);
    iRST = 1'b0;
    drive(1'b1, 1'b1, 12'hABC);
    check_reset_outputs();
    tick();
    iRST = 1'b1;
    pix_seen  = 0;
    done_seen = 0;
    iSTART = 1'b1;
    drive(1'b1, 1'b0, 12'h000);
    iSTART = 1'b0;
    for (int p = 0; p < HA; p++) drive(1'b1, 1'b1, DW'(900 + p));
    for (int b = 0; b < 3; b++) drive(1'b1, 1'b0, 12'h000);
    chk("t6_no_partial", pix_seen, 0);
    run_frame(HA, 1'b1, -1, -1, 1000);
    drain();
    end_test("t6", 32, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
